// File: rtl/tile_sequencer.sv
// ---------------------------------------------------------------------------
// tile_sequencer
//
// Runs one complete 3x3 matmul tile from a single command. The sequence is:
// weight load, systolic start, activation read, wait for systolic completion,
// then result writeback to the unified buffer. The instruction controller
// issues one command instead of driving each datapath control signal itself.
//
// Optional feature (macro TILE_SEQ_TIMEOUT_EN):
//   When the macro is defined, a 16-bit watchdog counter runs in every wait.
//   If it reaches TIMEOUT_CYC, the tile ends exactly as it would on abort.
//   When the macro is undefined, no counter exists and waits may stall forever.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_*               tile command (valid/ready), latched on accept
//   abort               synchronous abort of a running tile
//   wt_mem_rd_en/addr   weight DRAM read strobe and address
//   wt_fifo_wr          weight FIFO push
//   sys_start           systolic start pulse
//   sys_rows/signed/acc_clear
//                       systolic configuration, held from start until DONE
//   sys_busy, sys_done  systolic status
//   ub_busy             unified buffer busy
//   ub_rd_*             UB activation read request (pulse + addr + count)
//   ub_wr_*             UB result write request (pulse + addr + count)
//   busy, done, err     status: tile running, completion pulse, error pulse
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The source may change or drop cmd_valid at
// any time while cmd_ready is low. All cmd_* fields are captured on the
// transfer edge.
//
// Every strobe is registered. The FSM computes the value a strobe should take
// for the next cycle, so a strobe appears one cycle after its condition holds.
// ---------------------------------------------------------------------------
module tile_sequencer #(
  parameter int WT_ROWS     = 3,
  parameter int WT_STRIDE   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_wt_addr,
  input  logic [8:0]  cmd_act_addr,
  input  logic [8:0]  cmd_out_addr,
  input  logic [7:0]  cmd_rows,
  input  logic        cmd_signed,
  input  logic        cmd_acc_clear,
  input  logic        abort,
  output logic        wt_mem_rd_en,
  output logic [23:0] wt_mem_addr,
  output logic        wt_fifo_wr,
  output logic        sys_start,
  output logic [7:0]  sys_rows,
  output logic        sys_signed,
  output logic        sys_acc_clear,
  input  logic        sys_busy,
  input  logic        sys_done,
  input  logic        ub_busy,
  output logic        ub_rd_en,
  output logic [8:0]  ub_rd_addr,
  output logic [8:0]  ub_rd_count,
  output logic        ub_wr_en,
  output logic [8:0]  ub_wr_addr,
  output logic [8:0]  ub_wr_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int KW = (WT_ROWS > 1) ? $clog2(WT_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WT_LOAD, S_SYS_START, S_ACT_RD, S_WAIT_SYS, S_WRITEBACK, S_DONE
  } state_t;

  state_t state, state_nx;

  // Latched command fields. wt_ptr steps through the weight rows.
  logic [KW-1:0] wt_k;
  logic [23:0]   wt_ptr;
  logic [8:0]    act_addr_q, out_addr_q;
  logic [7:0]    rows_q;
  logic          signed_q, acc_clear_q;

  logic accept, fault, timeout;
  logic wt_d, sys_start_d, rd_d, wr_d, done_d, err_d;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef TILE_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        waiting;

  always_comb begin
    waiting = 1'b0;
    case (state)
      S_SYS_START:           waiting = sys_busy;
      S_ACT_RD, S_WRITEBACK: waiting = ub_busy;
      S_WAIT_SYS:            waiting = !sys_done;
      default:               waiting = 1'b0;
    endcase
  end

  // A fault fires in the cycle the counter would reach the limit. The tile
  // therefore ends with err exactly TIMEOUT_CYC cycles after the wait begins.
  assign timeout = waiting && (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (state_nx != state) wait_cnt <= '0;
    else if (waiting)           wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Abort (or timeout) only has an effect while a tile is running.
  // It has priority over every other event, including sys_done.
  assign fault = busy && (abort || timeout);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (fault) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (accept && cmd_rows != 8'd0)  state_nx = S_WT_LOAD;
        S_WT_LOAD:   if (wt_k == KW'(WT_ROWS - 1))    state_nx = S_SYS_START;
        S_SYS_START: if (!sys_busy)                   state_nx = S_ACT_RD;
        S_ACT_RD:    if (!ub_busy)                    state_nx = S_WAIT_SYS;
        S_WAIT_SYS:  if (sys_done)                    state_nx = S_WRITEBACK;
        S_WRITEBACK: if (!ub_busy)                    state_nx = S_DONE;
        S_DONE:                                       state_nx = S_IDLE;
        default:                                      state_nx = S_IDLE;
      endcase
    end
  end

  // Output logic: the value each strobe takes in the next cycle
  always_comb begin
    wt_d        = 1'b0;
    sys_start_d = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (fault) begin
      err_d = 1'b1;
    end else begin
      case (state)
        S_IDLE:      err_d       = accept && (cmd_rows == 8'd0);
        S_WT_LOAD:   wt_d        = 1'b1;
        S_SYS_START: sys_start_d = !sys_busy;
        S_ACT_RD:    rd_d        = !ub_busy;
        S_WRITEBACK: wr_d        = !ub_busy;
        S_DONE:      done_d      = 1'b1;
        default:     ;
      endcase
    end
  end

  // Command capture and weight row stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_k        <= '0;
      wt_ptr      <= '0;
      act_addr_q  <= '0;
      out_addr_q  <= '0;
      rows_q      <= '0;
      signed_q    <= 1'b0;
      acc_clear_q <= 1'b0;
    end else if (accept) begin
      wt_k        <= '0;
      wt_ptr      <= cmd_wt_addr;
      act_addr_q  <= cmd_act_addr;
      out_addr_q  <= cmd_out_addr;
      rows_q      <= cmd_rows;
      signed_q    <= cmd_signed;
      acc_clear_q <= cmd_acc_clear;
    end else if (state == S_WT_LOAD && !fault) begin
      wt_k   <= wt_k + KW'(1);
      wt_ptr <= wt_ptr + 24'(WT_STRIDE);   // wraps mod 2^24
    end
  end

  // Registered outputs. Address and count buses read zero when not strobing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_mem_rd_en  <= 1'b0;
      wt_fifo_wr    <= 1'b0;
      wt_mem_addr   <= '0;
      sys_start     <= 1'b0;
      sys_rows      <= '0;
      sys_signed    <= 1'b0;
      sys_acc_clear <= 1'b0;
      ub_rd_en      <= 1'b0;
      ub_rd_addr    <= '0;
      ub_rd_count   <= '0;
      ub_wr_en      <= 1'b0;
      ub_wr_addr    <= '0;
      ub_wr_count   <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      wt_mem_rd_en <= wt_d;
      wt_fifo_wr   <= wt_d;
      wt_mem_addr  <= wt_d ? wt_ptr : 24'd0;
      sys_start    <= sys_start_d;
      ub_rd_en     <= rd_d;
      ub_rd_addr   <= rd_d ? act_addr_q : 9'd0;
      ub_rd_count  <= rd_d ? {1'b0, rows_q} : 9'd0;
      ub_wr_en     <= wr_d;
      ub_wr_addr   <= wr_d ? out_addr_q : 9'd0;
      ub_wr_count  <= wr_d ? 9'd1 : 9'd0;
      done         <= done_d;
      err          <= err_d;
      // The systolic configuration appears with sys_start. It stays stable
      // through the DONE cycle and clears when the FSM returns to IDLE.
      if (sys_start_d) begin
        sys_rows      <= rows_q;
        sys_signed    <= signed_q;
        sys_acc_clear <= acc_clear_q;
      end else if (state_nx == S_IDLE) begin
        sys_rows      <= '0;
        sys_signed    <= 1'b0;
        sys_acc_clear <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tile_sequencer
//
// Drives tile commands with randomized wait lengths and background noise on
// the inputs that do not matter in a given state. The expected behaviour is
// a timeline: given the cycle a command is issued and how long each wait
// lasts, plain arithmetic gives the cycle in which every output must appear.
// All DUT outputs are packed into one vector and compared once per cycle
// against that timeline. Period 0 of each tile is the cycle in which
// cmd_valid is presented.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tile_sequencer;

  localparam int WT_ROWS     = 3;
  localparam int WT_STRIDE   = 8;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [23:0] cmd_wt_addr;
  logic [8:0]  cmd_act_addr, cmd_out_addr;
  logic [7:0]  cmd_rows;
  logic        cmd_signed, cmd_acc_clear, abort;
  logic        wt_mem_rd_en, wt_fifo_wr, sys_start, sys_signed, sys_acc_clear;
  logic [23:0] wt_mem_addr;
  logic [7:0]  sys_rows;
  logic        sys_busy, sys_done, ub_busy;
  logic        ub_rd_en, ub_wr_en;
  logic [8:0]  ub_rd_addr, ub_rd_count, ub_wr_addr, ub_wr_count;
  logic        busy, done, err;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        cmd_ready, busy, done, err, wt_rd, wt_wr;
    logic [23:0] wt_addr;
    logic        sys_start;
    logic [7:0]  sys_rows;
    logic        sys_signed, sys_acc_clear, ub_rd_en;
    logic [8:0]  ub_rd_addr, ub_rd_count;
    logic        ub_wr_en;
    logic [8:0]  ub_wr_addr, ub_wr_count;
  } obs_t;

  obs_t obs;
  assign obs = {cmd_ready, busy, done, err, wt_mem_rd_en, wt_fifo_wr, wt_mem_addr,
                sys_start, sys_rows, sys_signed, sys_acc_clear, ub_rd_en,
                ub_rd_addr, ub_rd_count, ub_wr_en, ub_wr_addr, ub_wr_count};

  always #5 clk = ~clk;

  tile_sequencer #(
    .WT_ROWS(WT_ROWS),
    .WT_STRIDE(WT_STRIDE),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wt_addr(cmd_wt_addr), .cmd_act_addr(cmd_act_addr),
    .cmd_out_addr(cmd_out_addr), .cmd_rows(cmd_rows),
    .cmd_signed(cmd_signed), .cmd_acc_clear(cmd_acc_clear), .abort(abort),
    .wt_mem_rd_en(wt_mem_rd_en), .wt_mem_addr(wt_mem_addr), .wt_fifo_wr(wt_fifo_wr),
    .sys_start(sys_start), .sys_rows(sys_rows), .sys_signed(sys_signed),
    .sys_acc_clear(sys_acc_clear), .sys_busy(sys_busy), .sys_done(sys_done),
    .ub_busy(ub_busy), .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .ub_rd_count(ub_rd_count), .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
    .ub_wr_count(ub_wr_count), .busy(busy), .done(done), .err(err)
  );

  function automatic obs_t idle_vec();
    obs_t v = '0;
    v.cmd_ready = 1'b1;
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_wt_addr = 0; cmd_act_addr = 0; cmd_out_addr = 0;
    cmd_rows = 0; cmd_signed = 0; cmd_acc_clear = 0; abort = 0;
    sys_busy = 0; sys_done = 0; ub_busy = 0;
  endtask

  // Run one tile.
  //   b/u/w : sys_busy / ub_busy(read) / ub_busy(write) wait lengths
  //   d     : cycles spent in WAIT_SYS before sys_done
  //   ta    : abort period (-1 none, -2 pick randomly)
  //   tmo   : the end at ta comes from the watchdog, not from abort
  task automatic run_tile(input string name, input logic [23:0] wt,
                          input logic [8:0] act, input logic [8:0] outa,
                          input logic [7:0] rows, input logic sgn, input logic clr,
                          input int b, input int u, input int d, input int w,
                          input int ta_in, input bit tmo);
    int   sys_st, t_ss, t_rd, wb0, t_wr, t_dn, t_end, noise_lim, ta;
    obs_t e;
    sys_st = 1 + WT_ROWS;            // first SYS_START period
    t_ss   = sys_st + b + 1;         // sys_start strobe
    t_rd   = t_ss + u + 1;           // ub_rd_en strobe, also WAIT_SYS entry
    wb0    = t_rd + d + 1;           // first WRITEBACK period
    t_wr   = wb0 + w + 1;            // ub_wr_en strobe, DONE state
    t_dn   = t_wr + 1;               // done pulse
    ta     = (ta_in == -2) ? int'($urandom_range(1, t_wr)) : ta_in;
    t_end  = (rows == 0) ? 1 : (ta >= 0) ? ta + 1 : t_dn;
    noise_lim = (rows == 0) ? 0 : (ta >= 0) ? ta : t_wr;

    for (int t = 0; t <= t_end; t++) begin
      @(posedge clk); #1;
      // stimulus for period t
      if (t == 0) begin
        cmd_valid = 1; cmd_wt_addr = wt; cmd_act_addr = act; cmd_out_addr = outa;
        cmd_rows = rows; cmd_signed = sgn; cmd_acc_clear = clr;
        abort = rbit();              // abort in IDLE must be ignored
      end else begin
        cmd_valid = (t <= noise_lim) ? rbit() : 1'b0;
        cmd_wt_addr = 24'($urandom); cmd_act_addr = 9'($urandom);
        cmd_out_addr = 9'($urandom); cmd_rows = 8'($urandom);
        cmd_signed = rbit(); cmd_acc_clear = rbit();
        abort = (t == ta && !tmo);
      end
      sys_busy = (t >= sys_st && t < sys_st + b) ? 1'b1 :
                 (t == sys_st + b) ? 1'b0 : rbit();
      if (t >= t_ss && t < t_ss + u)        ub_busy = 1'b1;
      else if (t == t_ss + u)               ub_busy = 1'b0;
      else if (t >= wb0 && t < wb0 + w)     ub_busy = 1'b1;
      else if (t == wb0 + w)                ub_busy = 1'b0;
      else                                  ub_busy = rbit();
      if (tmo && t >= t_rd)                 sys_done = 1'b0;
      else if (t == t_rd + d)               sys_done = 1'b1;
      else if (t >= t_rd && t < t_rd + d)   sys_done = 1'b0;
      else                                  sys_done = rbit();

      @(negedge clk);
      // expected outputs for period t
      e = idle_vec();
      if (rows == 0) begin
        e.err = (t == 1);
      end else if (ta >= 0 && t > ta) begin
        e.err = (t == ta + 1);
      end else begin
        e.busy      = (t >= 1 && t <= t_wr);
        e.cmd_ready = !e.busy;
        if (t >= 2 && t < 2 + WT_ROWS) begin
          e.wt_rd = 1; e.wt_wr = 1;
          e.wt_addr = wt + 24'((t - 2) * WT_STRIDE);
        end
        e.sys_start = (t == t_ss);
        if (t >= t_ss && t <= t_wr) begin
          e.sys_rows = rows; e.sys_signed = sgn; e.sys_acc_clear = clr;
        end
        if (t == t_rd) begin
          e.ub_rd_en = 1; e.ub_rd_addr = act; e.ub_rd_count = {1'b0, rows};
        end
        if (t == t_wr) begin
          e.ub_wr_en = 1; e.ub_wr_addr = outa; e.ub_wr_count = 9'd1;
        end
        e.done = (t == t_dn);
      end
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s t=%0d got=%h exp=%h", name, t, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== idle_vec()) begin
      fails++; $display("FAIL reset_hold got=%h exp=%h", obs, idle_vec());
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (obs !== idle_vec()) begin
      fails++; $display("FAIL reset_release got=%h exp=%h", obs, idle_vec());
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cmd_valid = 1; cmd_wt_addr = 24'h000200; cmd_rows = 8'd4;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk);
    @(negedge clk);                  // period 2: first weight row strobe
    checks++;
    if (wt_mem_rd_en !== 1'b1) begin
      fails++; $display("FAIL reset_mid_started got=%b exp=1", wt_mem_rd_en);
    end
    rst_n = 0;
    #1;
    checks++;
    if (obs !== idle_vec()) begin
      fails++; $display("FAIL reset_mid_async got=%h exp=%h", obs, idle_vec());
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== idle_vec()) begin
      fails++; $display("FAIL reset_mid_after got=%h exp=%h", obs, idle_vec());
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    run_tile("basic", 24'h000100, 9'h010, 9'h020, 8'd3, 1'b0, 1'b1, 0, 0, 0, 0, -1, 1'b0);
    run_tile("basic_signed", 24'h123450, 9'h1a5, 9'h0c3, 8'd200, 1'b1, 1'b0, 2, 1, 3, 2, -1, 1'b0);
  endtask

  task automatic test_zero_rows();
    run_tile("zero_rows", 24'h000300, 9'h011, 9'h022, 8'd0, 1'b1, 1'b1, 0, 0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_ub_busy();
    run_tile("ub_busy_rd", 24'h000400, 9'h033, 9'h044, 8'd7, 1'b0, 1'b0, 0, 5, 0, 0, -1, 1'b0);
    run_tile("ub_busy_wr", 24'h000400, 9'h033, 9'h044, 8'd7, 1'b0, 1'b0, 3, 0, 2, 4, -1, 1'b0);
  endtask

  task automatic test_abort();
    // period 7 is the second WAIT_SYS cycle when all waits are zero except d
    run_tile("abort_wait_sys", 24'h000500, 9'h055, 9'h066, 8'd9, 1'b1, 1'b0, 0, 0, 3, 0, 7, 1'b0);
    run_tile("after_abort", 24'h000600, 9'h077, 9'h088, 8'd2, 1'b0, 1'b1, 0, 0, 1, 0, -1, 1'b0);
    // abort coinciding with sys_done (period 6 + d) and abort in DONE
    run_tile("abort_vs_done", 24'h000700, 9'h099, 9'h0aa, 8'd5, 1'b0, 1'b0, 0, 0, 2, 0, 8, 1'b0);
    run_tile("abort_in_done", 24'h000800, 9'h0bb, 9'h0cc, 8'd5, 1'b0, 1'b0, 0, 0, 0, 0, 8, 1'b0);
  endtask

  task automatic test_wrap();
    run_tile("wrap", 24'hFFFFF8, 9'h101, 9'h102, 8'd1, 1'b0, 1'b0, 0, 0, 0, 0, -1, 1'b0);
  endtask

`ifdef TILE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    // WAIT_SYS entered in period 6; the watchdog ends it like an abort at 21
    run_tile("timeout", 24'h000900, 9'h0dd, 9'h0ee, 8'd3, 1'b0, 1'b0, 0, 0, 100, 0, 21, 1'b1);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] rows;
      int         ta;
      rows = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ta   = ($urandom_range(0, 3) == 0) ? -2 : -1;
      run_tile("random", 24'($urandom), 9'($urandom), 9'($urandom), rows,
               rbit(), rbit(), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(0, 4), ta, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_ub_busy();
    test_abort();
    test_wrap();
`ifdef TILE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
